// File: rtl/mem_sync_init_pkg.sv
// mem_sync_init_pkg: shared FSM state type and mode constants for the init-sweep RAM
package mem_sync_init_pkg;
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam int RDW_READ_FIRST    = 0;
  localparam int RDW_WRITE_THROUGH = 1;
  localparam int INIT_ZERO         = 0;
  localparam int INIT_ADDR         = 1;
endpackage

// File: rtl/mem_sync_init_array.sv
// mem_array: DEPTH x DATA_W storage, per-byte write enables, registered read port
//   clk, rst   : clock, async active-high reset (read register only, never the contents)
//   we, be     : write enable and byte enables; addr/wdata select word and data
//   re         : load rdata; gets the merged word when writing with WT=1, else the old word
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int WT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] old_w, merged;
  assign old_w = mem[addr];
  always_comb begin
    merged = old_w;
    for (int k = 0; k < DATA_W/8; k++)
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
  end
  always_ff @(posedge clk)
    if (we) mem[addr] <= merged;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= (we && WT != 0) ? merged : old_w;
endmodule

// File: rtl/mem_sync_init.sv
// mem_sync_init: single-port sync RAM with hardware init sweep, valid/ready requests, byte lanes
//   clk, rst (async, active-high); init_start/init_busy: re-init request and sweep-in-progress
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be: request handshake
//   rdata/rvalid: response one cycle after acceptance, rdata held between responses
module mem_sync_init
  import mem_sync_init_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int RDW_MODE  = 0,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_start,
  output logic                init_busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic sweep, acc;
  assign sweep     = state == ST_INIT;
  assign req_ready = state == ST_IDLE;
  assign init_busy = sweep;
  assign acc       = req_valid & req_ready;
  always_comb begin
    state_nx = sweep ? ((&cnt) ? ST_IDLE : ST_INIT) : (init_start ? ST_INIT : ST_IDLE);
    cnt_nx   = sweep ? cnt + ADDR_W'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rvalid <= acc;
    end
  // the sweep owns the write port while busy; requests are never accepted then
  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WT(RDW_MODE == RDW_WRITE_THROUGH)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (sweep | (acc & req_we)),
    .be    (sweep ? {(DATA_W/8){1'b1}} : req_be),
    .addr  (sweep ? cnt : req_addr),
    .wdata (sweep ? (INIT_MODE == INIT_ADDR ? DATA_W'(cnt) : '0) : req_wdata),
    .re    (acc),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_mem_sync_init.sv
// tb_mem_sync_init: directed + random checks of mem_sync_init (both RDW modes) against a word-array model
module tb_mem_sync_init;
  logic clk = 0, rst = 1, init_start = 0, req_valid = 0, req_we = 0;
  logic [3:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic [1:0] req_be = 0;
  logic busy0, ready0, rvalid0, busy1, ready1, rvalid1;
  logic [15:0] rdata0, rdata1;
  int total = 0, bad = 0;
  logic [15:0] mem_m [16];
  int sweep_left = 16;
  logic exp_rv = 0;
  logic [15:0] exp_rd0 = 0, exp_rd1 = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_sync_init #(.RDW_MODE(0)) dut0 (.clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy0),
    .req_valid(req_valid), .req_ready(ready0), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rdata(rdata0), .rvalid(rvalid0));
  mem_sync_init #(.RDW_MODE(1)) dut1 (.clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy1),
    .req_valid(req_valid), .req_ready(ready1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rdata(rdata1), .rvalid(rvalid1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic rdy;
    rdy = sweep_left == 0;
    chk({tag, ".ready0"}, ready0, rdy);
    chk({tag, ".busy0"}, busy0, !rdy);
    chk({tag, ".ready1"}, ready1, rdy);
    chk({tag, ".busy1"}, busy1, !rdy);
    chk({tag, ".rvalid0"}, rvalid0, exp_rv);
    chk({tag, ".rvalid1"}, rvalid1, exp_rv);
    chk({tag, ".rdata0"}, rdata0, exp_rd0);
    chk({tag, ".rdata1"}, rdata1, exp_rd1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    sweep_left = 16; exp_rv = 0; exp_rd0 = 0; exp_rd1 = 0;
    chk_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic cyc(input string tag, input logic v, input logic we, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] b, input logic is);
    logic [15:0] old, nw;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = b; init_start = is;
    @(posedge clk);
    if (sweep_left > 0) begin
      mem_m[16 - sweep_left] = 16'(16 - sweep_left);
      sweep_left--;
      exp_rv = 0;
    end else begin
      exp_rv = v;
      if (v) begin
        old = mem_m[a];
        nw = old;
        for (int k = 0; k < 2; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
        exp_rd0 = old;
        exp_rd1 = we ? nw : old;
        if (we) mem_m[a] = nw;
      end
      if (is) sweep_left = 16;
    end
    #1;
    chk_all(tag);
    req_valid = 0; init_start = 0;
  endtask

  initial begin
    do_reset("rst0");
    for (int i = 0; i < 16; i++) cyc("sweep1", 0, 0, 0, 0, 0, 0);
    chk("t1.ready17", ready0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc("t1.read", 1, 0, 4'(i), 0, 0, 0);
      chk("t1.ident", rdata0, 32'(i));
    end
    cyc("t2.w", 1, 1, 5, 16'hABCD, 2'b11, 0);
    cyc("t2.r", 1, 0, 5, 0, 0, 0);
    chk("t2.abcd", rdata0, 16'hABCD);
    cyc("t2.wb", 1, 1, 5, 16'h1234, 2'b01, 0);
    cyc("t2.r2", 1, 0, 5, 0, 0, 0);
    chk("t2.ab34", rdata0, 16'hAB34);
    cyc("t2.be0", 1, 1, 5, 16'hFFFF, 2'b00, 0);
    cyc("t2.r3", 1, 0, 5, 0, 0, 0);
    chk("t2.be0keep", rdata0, 16'hAB34);
    cyc("t3.w", 1, 1, 3, 16'h00FF, 2'b11, 0);
    chk("t3.rdw0", rdata0, 16'h0003);
    chk("t3.rdw1", rdata1, 16'h00FF);
    cyc("t3.r", 1, 0, 3, 0, 0, 0);
    chk("t3.rd", rdata1, 16'h00FF);
    cyc("t4.init", 1, 0, 5, 0, 0, 1);
    chk("t4.resp", rdata0, 16'hAB34);
    chk("t4.rv", rvalid0, 1'b1);
    for (int i = 0; i < 16; i++) cyc("t4.sweep", 0, 0, 0, 0, 0, 0);
    cyc("t4.r", 1, 0, 5, 0, 0, 0);
    chk("t4.0005", rdata0, 16'h0005);
    cyc("t4.w", 1, 1, 9, 16'h5A5A, 2'b10, 0);
    do_reset("t5.pre");
    for (int i = 0; i < 7; i++) cyc("t5.sweep", 0, 0, 0, 0, 0, 0);
    #2;
    do_reset("t5.rst");
    for (int i = 0; i < 16; i++) cyc("t6.initreq", 1, 1, 4'(i), 16'hDEAD, 2'b11, 0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc("t6.stream", 1, 0, 4'(i), 0, 0, 0);
      if (rvalid0) pulses++;
      chk("t6.data", rdata0, 32'(i));
    end
    cyc("t6.idle", 0, 0, 0, 0, 0, 0);
    chk("t6.pulses", pulses, 16);
    for (int i = 0; i < 400; i++)
      cyc("rnd", $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 16'($urandom),
          2'($urandom), $urandom_range(0, 49) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
